spi_xfer_seq: RTL

Wishbone master that sequences the byte-wide SPI master core (2-bit register address, 8-bit data) on behalf of a simple valid/ready byte-stream client. After reset it programs the control and extension registers once. It then turns each accepted transmit byte into the full register sequence: write data, poll status, read received byte, clear the interrupt flag. It sits beside the AHB-to-Wishbone bridge on the same Wishbone segment and is the only other master that touches the SPI core.

---
 rtl/spi_xfer_seq_pkg.sv | 31 +++
 rtl/spi_xfer_seq_wb_single_master.sv | 60 ++++++
 rtl/spi_xfer_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM states and
// register map / status bits of the byte-wide SPI master core.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        INIT_CR,
        INIT_ER,
        IDLE,
        WR_DR,
        RD_SR,
        CLR_SR,
        RD_DR,
        RSP
    } state_t;

    localparam logic [1:0] SPCR = 2'd0;
    localparam logic [1:0] SPSR = 2'd1;
    localparam logic [1:0] SPDR = 2'd2;
    localparam logic [1:0] SPER = 2'd3;

    localparam int unsigned RFEMPTY = 0;
    localparam int unsigned SPIF    = 7;

    // Writing a one to SPIF clears the interrupt flag
    localparam logic [7:0] SPSR_SPIF_CLR = 8'(1 << SPIF);

    function automatic logic is_access(input state_t s);
        return !(s == IDLE || s == RSP);
    endfunction

endpackage

// File: rtl/spi_xfer_seq_wb_single_master.sv
// Single Wishbone access engine: one classic access per start pulse,
// terminated by ack or by an ack timeout after ACK_LIMIT strobe cycles.
module wb_single_master #(
    parameter int unsigned ACK_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] rdata,
    output logic       wb_cyc,
    output logic       wb_stb,
    output logic       wb_we,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data_out,
    input  logic [7:0] wb_data_in,
    input  logic       wb_ack
);

    localparam int unsigned   AW       = $clog2(ACK_LIMIT + 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_LIMIT - 1);

    logic [AW-1:0] ack_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wb_cyc      <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data_out <= '0;
            ack_cnt     <= '0;
        end else if (!wb_cyc) begin
            if (start) begin
                wb_cyc      <= 1'b1;
                wb_we       <= we;
                wb_addr     <= addr;
                wb_data_out <= wdata;
                ack_cnt     <= '0;
            end
        end else if (done || timeout) begin
            wb_cyc <= 1'b0;
        end else if (ack_cnt != '1) begin
            ack_cnt <= ack_cnt + 1'b1;
        end
    end

    // ack_cnt holds the number of strobe cycles already spent, so the
    // timeout fires in the last permitted strobe cycle
    assign wb_stb  = wb_cyc;
    assign busy    = wb_cyc;
    assign done    = wb_cyc && wb_ack;
    assign timeout = wb_cyc && !wb_ack && (ack_cnt == ACK_LAST);
    assign rdata   = wb_data_in;

endmodule

// File: rtl/spi_xfer_seq.sv
// Wishbone master that initialises the SPI core and runs one full
// write/poll/read/clear register sequence per client byte.
module spi_xfer_seq
    import spi_seq_pkg::*;
#(
    parameter logic [7:0]  SPCR_INIT  = 8'h50,
    parameter logic [7:0]  SPER_INIT  = 8'h00,
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned ACK_LIMIT  = 16
) (
    input  logic       wb_clk,
    input  logic       wb_rstn,
    input  logic       req_valid,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    input  logic       rsp_ready,
    output logic       init_done,
    output logic       wb_cyc,
    output logic       wb_stb,
    output logic       wb_we,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data_out,
    input  logic [7:0] wb_data_in,
    input  logic       wb_ack
);

    localparam int unsigned   PW       = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    state_t        state, state_n;
    logic [PW-1:0] poll_cnt, poll_n, poll_inc;
    logic [7:0]    tx_byte, tx_n;
    logic [7:0]    rsp_data_n;
    logic          rsp_err_n, init_done_n;

    logic          acc_start, acc_we;
    logic [1:0]    acc_addr;
    logic [7:0]    acc_wdata;
    logic          busy, done, timeout;
    logic [7:0]    rdata;

    wb_single_master #(
        .ACK_LIMIT(ACK_LIMIT)
    ) u_acc (
        .clk        (wb_clk),
        .rstn       (wb_rstn),
        .start      (acc_start),
        .we         (acc_we),
        .addr       (acc_addr),
        .wdata      (acc_wdata),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .rdata      (rdata),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data_out(wb_data_out),
        .wb_data_in (wb_data_in),
        .wb_ack     (wb_ack)
    );

    always_ff @(posedge wb_clk) begin
        if (!wb_rstn) begin
            state     <= INIT_CR;
            poll_cnt  <= '0;
            tx_byte   <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            poll_cnt  <= poll_n;
            tx_byte   <= tx_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        poll_n      = poll_cnt;
        tx_n        = tx_byte;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        init_done_n = init_done;
        acc_we      = 1'b0;
        acc_addr    = SPCR;
        acc_wdata   = '0;
        poll_inc    = (poll_cnt == POLL_MAX) ? poll_cnt : poll_cnt + 1'b1;

        case (state)
            INIT_CR: begin
                acc_we    = 1'b1;
                acc_addr  = SPCR;
                acc_wdata = SPCR_INIT;
                if (done) state_n = INIT_ER;
            end
            INIT_ER: begin
                acc_we    = 1'b1;
                acc_addr  = SPER;
                acc_wdata = SPER_INIT;
                if (done) begin
                    init_done_n = 1'b1;
                    state_n     = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    tx_n       = req_data;
                    rsp_data_n = '0;
                    rsp_err_n  = 1'b0;
                    state_n    = WR_DR;
                end
            end
            WR_DR: begin
                acc_we    = 1'b1;
                acc_addr  = SPDR;
                acc_wdata = tx_byte;
                if (done) begin
                    poll_n  = '0;
                    state_n = RD_SR;
                end
            end
            RD_SR: begin
                acc_addr = SPSR;
                if (done) begin
                    poll_n = poll_inc;
                    if (!rdata[RFEMPTY]) begin
                        state_n = RD_DR;
                    end else if (poll_inc == POLL_MAX) begin
                        rsp_err_n  = 1'b1;
                        rsp_data_n = '0;
                        state_n    = CLR_SR;
                    end
                end
            end
            RD_DR: begin
                acc_addr = SPDR;
                if (done) begin
                    rsp_data_n = rdata;
                    state_n    = CLR_SR;
                end
            end
            CLR_SR: begin
                acc_we    = 1'b1;
                acc_addr  = SPSR;
                acc_wdata = SPSR_SPIF_CLR;
                if (done) state_n = RSP;
            end
            RSP: begin
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = INIT_CR;
        endcase

        // A lost ack restarts init, but aborts a transfer straight to an error response
        if (timeout) begin
            if (state == INIT_CR || state == INIT_ER) begin
                state_n = INIT_CR;
            end else begin
                rsp_err_n  = 1'b1;
                rsp_data_n = '0;
                state_n    = RSP;
            end
        end

        acc_start = is_access(state) && !busy;
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RSP);

endmodule
